keystream_serialiser: RTL and testbench

- Parametrised successor to the fixed 16x32 word serialiser.
- Accepts one ChaCha20 keystream block (NUM_WORDS words of WORD_W bits) through a valid/ready handshake.
- Emits the block as a byte stream in RFC 8439 order, OUT_BYTES bytes per beat, with a valid/ready handshake, byte-keep mask, last flag and a partial-block length.
- Sits between the ChaCha20 block core and the XOR/Poly1305 datapath.

---
 rtl/keystream_serialiser_if.sv | 28 ++
 rtl/keystream_serialiser.sv | 190 +++++++++++++++++++
 tb/tb_keystream_serialiser.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/keystream_serialiser_if.sv
// Handshake bundle for keystream_serialiser: block input side and byte-beat output side.
// master = block source plus beat sink; slave = the serialiser.
interface keystream_serialiser_if #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 16,
  parameter int OUT_BYTES = 1,
  parameter int LEN_W     = 7
);
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_WORDS*WORD_W-1:0] in_block;
  logic [LEN_W-1:0]            in_len;
  logic                        out_valid;
  logic                        out_ready;
  logic [OUT_BYTES*8-1:0]      out_data;
  logic [OUT_BYTES-1:0]        out_keep;
  logic                        out_last;

  modport master (
    output in_valid, in_block, in_len, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

  modport slave (
    input  in_valid, in_block, in_len, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/keystream_serialiser.sv
// keystream_serialiser: streams one ChaCha20 keystream block as RFC 8439-ordered byte beats.
// Define KS_SER_PREFETCH_EN to add a second block slot for zero-bubble back-to-back blocks.
module keystream_serialiser #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 16,
  parameter int OUT_BYTES = 1,
  parameter int LEN_W     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  keystream_serialiser_if.slave ks,
  output logic                  busy
);
  localparam int BLK_W  = NUM_WORDS * WORD_W;
  localparam int BLK_B  = BLK_W / 8;
  localparam int BEAT_W = OUT_BYTES * 8;
  localparam int OB_SH  = $clog2(OUT_BYTES);
  localparam int IDX_W  = LEN_W + 4;
  localparam int SH_W   = LEN_W + 7;

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t               state_r, state_s;
  logic [BLK_W-1:0]     blk_r, blk_s;
  logic [LEN_W-1:0]     len_r, len_s;
  logic [LEN_W-1:0]     beat_r, beat_s;
  logic [LEN_W-1:0]     in_len_eff_s;
  logic                 in_ready_r, in_ready_s;
  logic                 out_valid_r, out_valid_s;
  logic                 out_last_r, out_last_s;
  logic [BEAT_W-1:0]    out_data_r, out_data_s;
  logic [BEAT_W-1:0]    beat_sh_s;
  logic [OUT_BYTES-1:0] out_keep_r, out_keep_s;
  logic [IDX_W-1:0]     nb_s, lane_idx_s;
  logic [SH_W-1:0]      sh_amt_s;
  logic                 accept_s, fire_s, final_s;
`ifdef KS_SER_PREFETCH_EN
  logic                 pf_full_r, pf_full_s;
  logic [BLK_W-1:0]     pf_blk_r, pf_blk_s;
  logic [LEN_W-1:0]     pf_len_r, pf_len_s;
`endif

  assign accept_s = ks.in_valid && in_ready_r;
  assign fire_s   = out_valid_r && ks.out_ready;
  assign final_s  = fire_s && out_last_r;

  // Length normalisation: zero and oversize lengths both mean a full block
  always_comb begin
    if ((ks.in_len == '0) || (ks.in_len > LEN_W'(BLK_B))) begin
      in_len_eff_s = LEN_W'(BLK_B);
    end else begin
      in_len_eff_s = ks.in_len;
    end
  end

  // Next-state: block capture, beat advance and end-of-block hand-over
  always_comb begin
    state_s = state_r;
    blk_s   = blk_r;
    len_s   = len_r;
    beat_s  = beat_r;
`ifdef KS_SER_PREFETCH_EN
    pf_full_s = pf_full_r;
    pf_blk_s  = pf_blk_r;
    pf_len_s  = pf_len_r;
`endif
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = S_SEND;
          blk_s   = ks.in_block;
          len_s   = in_len_eff_s;
          beat_s  = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SEND: begin
        if (final_s) begin
          beat_s = '0;
`ifdef KS_SER_PREFETCH_EN
          // A full slot wins; in_ready is low then, so no accept can collide with it
          if (pf_full_r) begin
            blk_s     = pf_blk_r;
            len_s     = pf_len_r;
            pf_full_s = 1'b0;
          end else if (accept_s) begin
            blk_s = ks.in_block;
            len_s = in_len_eff_s;
          end else begin
            state_s = S_IDLE;
          end
`else
          state_s = S_IDLE;
`endif
        end else begin
          beat_s = fire_s ? (beat_r + LEN_W'(1)) : beat_r;
`ifdef KS_SER_PREFETCH_EN
          if (accept_s) begin
            pf_full_s = 1'b1;
            pf_blk_s  = ks.in_block;
            pf_len_s  = in_len_eff_s;
          end else begin
            pf_full_s = pf_full_r;
          end
`endif
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // Output decode of the next state, captured into the output registers
  always_comb begin
    out_valid_s = 1'b0;
    out_last_s  = 1'b0;
    out_data_s  = '0;
    out_keep_s  = '0;
    lane_idx_s  = '0;
    nb_s        = (IDX_W'(len_s) + IDX_W'(OUT_BYTES - 1)) >> OB_SH;
    sh_amt_s    = SH_W'(beat_s) << (OB_SH + 3);
    beat_sh_s   = BEAT_W'(blk_s >> sh_amt_s);
    if (state_s == S_SEND) begin
      out_valid_s = 1'b1;
      out_last_s  = (IDX_W'(beat_s) == (nb_s - IDX_W'(1)));
      for (int k = 0; k < OUT_BYTES; k++) begin
        lane_idx_s = (IDX_W'(beat_s) << OB_SH) + IDX_W'(k);
        if (lane_idx_s < IDX_W'(len_s)) begin
          out_keep_s[k]       = 1'b1;
          out_data_s[8*k +: 8] = beat_sh_s[8*k +: 8];
        end else begin
          out_keep_s[k]       = 1'b0;
          out_data_s[8*k +: 8] = 8'h00;
        end
      end
    end else begin
      out_valid_s = 1'b0;
      out_last_s  = 1'b0;
    end
`ifdef KS_SER_PREFETCH_EN
    in_ready_s = !pf_full_s;
`else
    in_ready_s = (state_s == S_IDLE);
`endif
  end

  // State and output registers; reset discards any held block immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      blk_r       <= '0;
      len_r       <= '0;
      beat_r      <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= '0;
      out_keep_r  <= '0;
`ifdef KS_SER_PREFETCH_EN
      pf_full_r   <= 1'b0;
      pf_blk_r    <= '0;
      pf_len_r    <= '0;
`endif
    end else begin
      state_r     <= state_s;
      blk_r       <= blk_s;
      len_r       <= len_s;
      beat_r      <= beat_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
      out_last_r  <= out_last_s;
      out_data_r  <= out_data_s;
      out_keep_r  <= out_keep_s;
`ifdef KS_SER_PREFETCH_EN
      pf_full_r   <= pf_full_s;
      pf_blk_r    <= pf_blk_s;
      pf_len_r    <= pf_len_s;
`endif
    end
  end

  assign ks.in_ready  = in_ready_r;
  assign ks.out_valid = out_valid_r;
  assign ks.out_last  = out_last_r;
  assign ks.out_data  = out_data_r;
  assign ks.out_keep  = out_keep_r;
  assign busy         = (state_r == S_SEND);
endmodule

// File: tb/tb_keystream_serialiser.sv
// Self-checking bench for keystream_serialiser: 1-byte and 4-byte beat instances against a byte-stream model.
module tb_keystream_serialiser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keystream_serialiser_if #(.WORD_W(32), .NUM_WORDS(16), .OUT_BYTES(1), .LEN_W(7)) i1 ();
  keystream_serialiser_if #(.WORD_W(32), .NUM_WORDS(16), .OUT_BYTES(4), .LEN_W(7)) i4 ();
  logic busy1, busy4;

  keystream_serialiser #(.WORD_W(32), .NUM_WORDS(16), .OUT_BYTES(1), .LEN_W(7)) dut1 (
    .clk(clk), .rst(rst), .ks(i1.slave), .busy(busy1));
  keystream_serialiser #(.WORD_W(32), .NUM_WORDS(16), .OUT_BYTES(4), .LEN_W(7)) dut4 (
    .clk(clk), .rst(rst), .ks(i4.slave), .busy(busy4));

  logic         sel = 1'b0;
  logic         v1 = 1'b0, v4 = 1'b0, r1 = 1'b0, r4 = 1'b0;
  logic [511:0] blk_d = '0;
  logic [6:0]   len_d = '0;

  assign i1.in_valid = v1;  assign i1.in_block = blk_d; assign i1.in_len = len_d; assign i1.out_ready = r1;
  assign i4.in_valid = v4;  assign i4.in_block = blk_d; assign i4.in_len = len_d; assign i4.out_ready = r4;

  logic        o_valid, o_last, o_in_ready, o_busy;
  logic [31:0] o_data;
  logic [3:0]  o_keep;
  assign o_valid    = sel ? i4.out_valid : i1.out_valid;
  assign o_last     = sel ? i4.out_last  : i1.out_last;
  assign o_in_ready = sel ? i4.in_ready  : i1.in_ready;
  assign o_busy     = sel ? busy4        : busy1;
  assign o_data     = sel ? i4.out_data  : {24'h000000, i1.out_data};
  assign o_keep     = sel ? i4.out_keep  : {3'b000, i1.out_keep};

  int checks = 0;
  int failures = 0;

  logic [511:0] src_blk[$];
  logic [6:0]   src_len[$];
  logic [31:0]  e_data[$];
  logic [3:0]   e_keep[$];
  logic         e_last[$];
  logic [511:0] blk_a;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  // Reference: byte b of the block is bits [8b +: 8]; cut the first len bytes into OB-byte beats
  task automatic add_block(input logic [511:0] b, input logic [6:0] l);
    int ob, len_eff, nb, idx;
    logic [31:0] d;
    logic [3:0] kp;
    ob = sel ? 4 : 1;
    len_eff = ((l == 7'd0) || (l > 7'd64)) ? 64 : int'(l);
    nb = (len_eff + ob - 1) / ob;
    src_blk.push_back(b);
    src_len.push_back(l);
    for (int n = 0; n < nb; n++) begin
      d = '0;
      kp = '0;
      for (int k = 0; k < ob; k++) begin
        idx = n * ob + k;
        if (idx < len_eff) begin
          d[8*k +: 8] = b[8*idx +: 8];
          kp[k] = 1'b1;
        end
      end
      e_data.push_back(d);
      e_keep.push_back(kp);
      e_last.push_back(n == nb - 1);
    end
  endtask

  task automatic drive(input logic valid, input logic ready);
    if (sel) begin v4 = valid; r4 = ready; v1 = 1'b0; r1 = 1'b0; end
    else     begin v1 = valid; r1 = ready; v4 = 1'b0; r4 = 1'b0; end
    blk_d = valid ? src_blk[0] : '0;
    len_d = valid ? src_len[0] : '0;
  endtask

  // Cycle loop at negedges: check any shown beat, then drive inputs and account for handshakes
  task automatic run_stream(input int ready_pct, input int stall_beat, input int stall_cyc,
                            input int abort_beat, input int exp_gaps);
    int cyc, done, stall_n, gaps;
    bit started, prev_stall, want_next, aborted;
    logic ov, irdy, valid, ready;
    cyc = 0; done = 0; stall_n = 0; gaps = 0;
    started = 0; prev_stall = 0; want_next = 0; aborted = 0;
    while ((src_blk.size() > 0 || e_data.size() > 0) && cyc < 3000) begin
      ov = o_valid;
      irdy = o_in_ready;
      if (want_next) chk("first_beat_latency", ov, 1'b1);
      if (prev_stall) chk("valid_held", ov, 1'b1);
      want_next = 0;
      if (ov) begin
        started = 1;
        chk("beat_expected", e_data.size() > 0, 1'b1);
        if (e_data.size() > 0) begin
          chk("out_data", o_data, e_data[0]);
          chk("out_keep", o_keep, e_keep[0]);
          chk("out_last", o_last, e_last[0]);
        end
      end else if (started && e_data.size() > 0) begin
        gaps++;
      end
      if (abort_beat >= 0 && done == abort_beat && ov) begin
        #2 rst = 1'b0;
        #1;
        chk("abort_valid", o_valid, 1'b0);
        chk("abort_last", o_last, 1'b0);
        chk("abort_keep", o_keep, 4'h0);
        chk("abort_data", o_data, 32'h0);
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_in_ready", o_in_ready, 1'b0);
        aborted = 1;
        break;
      end
      valid = (src_blk.size() > 0);
      if (stall_beat >= 0 && done == stall_beat && ov && stall_n < stall_cyc) begin
        ready = 1'b0;
        stall_n++;
      end else begin
        ready = ($urandom_range(99) < ready_pct);
      end
      drive(valid, ready);
      prev_stall = ov && !ready;
      if (ov && ready && e_data.size() > 0) begin
        void'(e_data.pop_front()); void'(e_keep.pop_front()); void'(e_last.pop_front());
        done++;
      end
      if (valid && irdy) begin
        want_next = !ov;
        void'(src_blk.pop_front()); void'(src_len.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    if (!aborted) begin
      chk("stream_complete", (src_blk.size() == 0) && (e_data.size() == 0), 1'b1);
      chk("idle_busy", o_busy, 1'b0);
      chk("idle_valid", o_valid, 1'b0);
      if (exp_gaps >= 0) chk("block_gap", gaps, exp_gaps);
    end
    src_blk.delete(); src_len.delete();
    e_data.delete(); e_keep.delete(); e_last.delete();
    drive(1'b0, 1'b0);
    if (aborted) begin
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) blk_a[8*i +: 8] = 8'(i);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid1", i1.out_valid, 1'b0);
    chk("rst_ready1", i1.in_ready, 1'b0);
    chk("rst_data1", i1.out_data, 8'h00);
    chk("rst_keep4", i4.out_keep, 4'h0);
    chk("rst_last4", i4.out_last, 1'b0);
    chk("rst_busy4", busy4, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready1", i1.in_ready, 1'b1);
    chk("post_rst_ready4", i4.in_ready, 1'b1);

    sel = 1'b0; add_block(blk_a, 7'd64);  run_stream(100, -1, 0, -1, -1);
    sel = 1'b1; add_block(blk_a, 7'd10);  run_stream(100, -1, 0, -1, -1);
    sel = 1'b0; add_block(blk_a, 7'd64);  run_stream(100, 3, 5, -1, -1);
    sel = 1'b0; add_block(rand_block(), 7'd0); add_block(rand_block(), 7'd100);
    run_stream(80, -1, 0, -1, -1);

    sel = 1'b1;
    for (int i = 0; i < 5; i++) add_block(rand_block(), 7'($urandom_range(127)));
    run_stream(60, -1, 0, -1, -1);
    sel = 1'b0;
    for (int i = 0; i < 3; i++) add_block(rand_block(), 7'($urandom_range(127)));
    run_stream(70, 2, 3, -1, -1);

    sel = 1'b0; add_block(blk_a, 7'd64);  run_stream(100, -1, 0, 32, -1);
    sel = 1'b0; add_block(blk_a, 7'd64);  run_stream(100, -1, 0, -1, -1);

    sel = 1'b1; add_block(blk_a, 7'd64); add_block(rand_block(), 7'd64);
`ifdef KS_SER_PREFETCH_EN
    run_stream(100, -1, 0, -1, 0);
`else
    run_stream(100, -1, 0, -1, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
